// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters with a single registered
// output stage that carries colour, syncs, display_active and line/frame pulses.
module vga_timing_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int COLOR_W    = 4,
  parameter int X_W        = 12,
  parameter int Y_W        = 11
) (
  input  logic               pixel_clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [COLOR_W-1:0] red_in,
  input  logic [COLOR_W-1:0] green_in,
  input  logic [COLOR_W-1:0] blue_in,
  output logic [COLOR_W-1:0] red_out,
  output logic [COLOR_W-1:0] green_out,
  output logic [COLOR_W-1:0] blue_out,
  output logic               h_sync_out,
  output logic               v_sync_out,
  output logic [X_W-1:0]     h_position,
  output logic [Y_W-1:0]     v_position,
  output logic               display_active,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_VIS_END  = X_W'(H_DISPLAY);
  localparam logic [X_W-1:0] H_SYNC_BEG = X_W'(H_DISPLAY + H_FRONT);
  localparam logic [X_W-1:0] H_SYNC_END = X_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_VIS_END  = Y_W'(V_DISPLAY);
  localparam logic [Y_W-1:0] V_SYNC_BEG = Y_W'(V_DISPLAY + V_FRONT);
  localparam logic [Y_W-1:0] V_SYNC_END = Y_W'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [X_W-1:0] h_cnt;
  logic [Y_W-1:0] v_cnt;
  logic           h_wrap;
  logic           v_wrap;
  logic           visible;
  logic           h_in_sync;
  logic           v_in_sync;

  assign h_position = h_cnt;
  assign v_position = v_cnt;

  assign h_wrap    = (h_cnt == H_LAST);
  assign v_wrap    = (v_cnt == V_LAST);
  assign visible   = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
  assign h_in_sync = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign v_in_sync = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      h_cnt          <= '0;
      v_cnt          <= '0;
      red_out        <= '0;
      green_out      <= '0;
      blue_out       <= '0;
      display_active <= 1'b0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
      h_sync_out     <= ~H_SYNC_POL;
      v_sync_out     <= ~V_SYNC_POL;
    end else if (enable) begin
      h_cnt <= h_wrap ? '0 : h_cnt + X_W'(1);
      if (h_wrap) begin
        v_cnt <= v_wrap ? '0 : v_cnt + Y_W'(1);
      end
      // Output stage shows the pixel at the pre-increment position.
      red_out        <= visible ? red_in   : '0;
      green_out      <= visible ? green_in : '0;
      blue_out       <= visible ? blue_in  : '0;
      display_active <= visible;
      line_start     <= (h_cnt == '0);
      frame_start    <= (h_cnt == '0) && (v_cnt == '0);
      h_sync_out     <= h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
      v_sync_out     <= v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
    end else begin
      // Frozen: counters hold, output stage blanks.
      red_out        <= '0;
      green_out      <= '0;
      blue_out       <= '0;
      display_active <= 1'b0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
      h_sync_out     <= ~H_SYNC_POL;
      v_sync_out     <= ~V_SYNC_POL;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in clocks.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in clocks.
REQ-005 Parameter V_DISPLAY, default 480, visible lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 Parameter H_SYNC_POL, default 0, active level of h_sync_out.
REQ-010 Parameter V_SYNC_POL, default 0, active level of v_sync_out.
REQ-011 Parameter COLOR_W, default 4, bits per colour channel.
REQ-012 Parameter X_W, default 12, and Y_W, default 11, position counter widths.
REQ-013 Port pixel_clock, input, 1, the single clock; all state on its rising edge.
REQ-014 Port reset, input, 1, asynchronous active-high reset.
REQ-015 Port enable, input, 1, run/freeze control for the timing counters.
REQ-016 Ports red_in, green_in, blue_in, input, COLOR_W each, pixel colour for the current h_position/v_position.
REQ-017 Ports red_out, green_out, blue_out, output, COLOR_W each, registered colour to the DAC.
REQ-018 Ports h_sync_out, v_sync_out, output, 1 each, registered syncs.
REQ-019 Ports h_position, output, X_W, and v_position, output, Y_W, the current counter values.
REQ-020 Port display_active, output, 1, registered; high when the outputs carry a visible pixel.
REQ-021 Ports line_start and frame_start, output, 1 each, registered single-cycle pulses.

Function
REQ-022 H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK and V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK; both counters SHALL be single-clock-domain (no derived clocks).
REQ-023 The h counter SHALL count 0..H_TOTAL-1, then wrap to 0, advancing one per clock while enable=1.
REQ-024 The v counter SHALL advance only on the clock where the h counter wraps (H_TOTAL-1 -> 0), wrapping V_TOTAL-1 -> 0 on the same edge as the h wrap.
REQ-025 Positions SHALL be the raw counters, combinational from registers; regions: visible h < H_DISPLAY; sync H_DISPLAY+H_FRONT <= h < H_DISPLAY+H_FRONT+H_SYNC; vertical analogous.
REQ-026 Latency SHALL be exactly one clock: red_in/green_in/blue_in sampled at positions (x,y) appear on the outputs the next cycle, together with the syncs and display_active decoded from (x,y).
REQ-027 Colour outputs SHALL be 0 whenever the registered display_active=0.
REQ-028 h_sync_out SHALL equal H_SYNC_POL when in the h sync region and ~H_SYNC_POL otherwise; v_sync_out likewise, using the v counter only.
REQ-029 line_start SHALL pulse for one cycle with the outputs for h=0; frame_start SHALL pulse for one cycle with the outputs for h=0, v=0.
REQ-030 With enable=0, the counters SHALL hold; the next output register SHALL drive colours 0, display_active 0, pulses 0, and both syncs inactive.
REQ-031 When enable returns to 1, counting SHALL resume from the held value with no skipped or repeated count.
REQ-032 Counter widths SHALL hold H_TOTAL-1 and V_TOTAL-1; counter comparisons SHALL be unsigned at counter width.

Reset
REQ-033 While reset=1, asynchronously: counters 0, colours 0, display_active 0, line_start 0, frame_start 0, syncs inactive (~H_SYNC_POL, ~V_SYNC_POL).
REQ-034 Reset mid-frame SHALL abandon the frame; after release, the first enabled edge SHALL present the outputs for (0,0) with line_start=frame_start=1.

Verification
REQ-035 Defaults, reset release with enable=1 and red_in=4'hF -> next cycle frame_start=1, line_start=1, display_active=1, red_out=4'hF; h_position=1.
REQ-036 Defaults, h=655 -> 656 -> h_sync_out goes 0 for exactly 96 cycles, starting one cycle after h_position=656; line period 800 clocks.
REQ-037 Defaults, full frame -> v_sync_out is low for exactly 2x800 clocks starting with the outputs for v=490, h=0; frame_start period 420000 clocks.
REQ-038 H_SYNC_POL=1, V_SYNC_POL=1, 800x600 timing (40/128/88, 1/4/23) -> syncs active-high; reset values low; line 1056, frame 628 lines.
REQ-039 enable=0 at h=100 for 7 cycles -> positions frozen at 100, outputs blank with inactive syncs; resume -> h_position=101 one enabled edge after release.
REQ-040 reset pulse at (h=300, v=200) -> immediate blank/inactive outputs; after release, frame_start pulses and counting restarts at (0,0).
